// File: rtl/arbiter_rr2.sv
// arbiter_rr2 -- two-requester round-robin arbiter.
//
// Grants a shared resource to one of two bus masters. Grants are mutually
// exclusive and decode from a registered state, so they change only on the
// rising edge of clock. A request sampled at edge N shows its grant during
// cycle N+1.
//
// When both masters want the resource, the holder keeps it for at most
// MAX_HOLD consecutive cycles before it is handed to the waiting master.
// MAX_HOLD = 0 disables preemption, so the holder keeps the grant as long as
// it requests.
//
// Handshake: reqX is a level. The requester holds it high until its work is
// done. gntX high in a cycle means requester X owns the resource for that
// cycle. The arbiter never withdraws a grant except on release, preemption
// or reset.
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous reset, active low
//   req0   in   request from requester 0 (level)
//   req1   in   request from requester 1 (level)
//   gnt0   out  grant to requester 0
//   gnt1   out  grant to requester 1
//   busy   out  gnt0 | gnt1
//
// Debug: the FSM state is held in state_q (type arb_state_t) so checkers can
// bind to it.
module arbiter_rr2 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  // hold_cnt counts the cycles after entry into a grant state. It reads
  // MAX_HOLD-1 during the MAX_HOLD-th cycle of a grant. This is where
  // preemption fires.
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  // last_q names the requester that was granted most recently. A tie goes
  // to the other requester.
  logic             last_q, last_d;
  logic             hold_expired;

  // The >= comparison makes preemption work even if the waiting requester
  // rises only after the counter has saturated.
  assign hold_expired = (MAX_HOLD != 0) && (hold_q >= HOLD_LAST);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (req0) begin
          state_d = GNT0;
        end else if (req1) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!req0) begin
          state_d = req1 ? GNT1 : IDLE;
        end else if (req1 && hold_expired) begin
          state_d = GNT1;
        end
      end
      GNT1: begin
        if (!req1) begin
          state_d = req0 ? GNT0 : IDLE;
        end else if (req0 && hold_expired) begin
          state_d = GNT0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter and rotation bookkeeping apply to every transition in one
    // place, so each branch above only has to choose a destination.
    if (state_d == IDLE) begin
      hold_d = '0;
    end else if (state_d != state_q) begin
      hold_d = '0;
      last_d = (state_d == GNT1);
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);
  assign busy = gnt0 | gnt1;

endmodule

// File: tb/tb_arbiter_rr2.sv
module tb_arbiter_rr2;

  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;

  logic clock;
  logic reset;
  logic req0;
  logic req1;
  logic gnt0;
  logic gnt1;
  logic busy;

  int total = 0;
  int bad   = 0;

  // Expected {busy, gnt1, gnt0}, one entry for each clock edge.
  logic [2:0] exp_q[$];

  // Reference model. It tracks the owner (-1 = none), how many cycles the
  // owner has held the grant, and who wins the next tie.
  int m_owner  = -1;
  int m_run    = 0;
  int m_prefer = 0;

  arbiter_rr2 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .busy  (busy)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  task automatic model_grant(input int who);
    m_owner  = who;
    m_run    = 1;
    m_prefer = 1 - who;
  endtask

  task automatic model_step(input logic r0, input logic r1, input logic rst_n);
    logic rh, ro;
    if (!rst_n) begin
      m_owner  = -1;
      m_run    = 0;
      m_prefer = 0;
    end else if (m_owner < 0) begin
      if (r0 && r1) model_grant(m_prefer);
      else if (r0)  model_grant(0);
      else if (r1)  model_grant(1);
    end else begin
      rh = (m_owner == 1) ? r1 : r0;
      ro = (m_owner == 1) ? r0 : r1;
      if (!rh) begin
        if (ro) model_grant(1 - m_owner);
        else begin
          m_owner = -1;
          m_run   = 0;
        end
      end else if (ro && MAX_HOLD > 0 && m_run >= MAX_HOLD) begin
        model_grant(1 - m_owner);
      end else begin
        m_run++;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed busy/gnt1/gnt0=%b expected=%b at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs, steps the model on the edge and checks the
  // outputs 1 time unit after that edge.
  task automatic cyc(input string tag, input logic r0, input logic r1, input logic rst_n);
    logic [2:0] want;
    req0  = r0;
    req1  = r1;
    reset = rst_n;
    @(posedge clock);
    model_step(r0, r1, rst_n);
    exp_q.push_back({m_owner >= 0, m_owner == 1, m_owner == 0});
    #1;
    want = exp_q.pop_front();
    check(tag, {busy, gnt1, gnt0}, want);
    total++;
    assert ((gnt0 & gnt1) === 1'b0) else begin
      bad++;
      $error("FAIL mutex_%s: observed gnt0&gnt1=%b expected=0", tag, gnt0 & gnt1);
    end
  endtask

  task automatic do_reset();
    cyc("reset", 1'b0, 1'b0, 1'b0);
    cyc("reset", 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len0, len1, cnt1;
    bit seen1, back0;
    logic r0, r1, rn;

    req0  = 1'b0;
    req1  = 1'b0;
    reset = 1'b0;

    // 1: reset then idle
    do_reset();
    for (int i = 0; i < 3; i++) cyc("idle", 1'b0, 1'b0, 1'b1);

    // 2: single request held for 4 cycles
    for (int i = 0; i < 4; i++) cyc("single_hold", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cyc("single_release", 1'b0, 1'b0, 1'b1);

    // 3: tie right after reset, handoff with no gap, then another tie
    do_reset();
    cyc("tie_first", 1'b1, 1'b1, 1'b1);
    check("tie_first_is_0", {busy, gnt1, gnt0}, 3'b101);
    cyc("tie_hold", 1'b1, 1'b1, 1'b1);
    cyc("handoff", 1'b0, 1'b1, 1'b1);
    check("handoff_no_gap", {busy, gnt1, gnt0}, 3'b110);
    cyc("g1_hold", 1'b0, 1'b1, 1'b1);
    cyc("to_idle", 1'b0, 1'b0, 1'b1);
    cyc("tie_again", 1'b1, 1'b1, 1'b1);
    check("tie_again_is_0", {busy, gnt1, gnt0}, 3'b101);
    cyc("to_idle", 1'b0, 1'b0, 1'b1);

    // 4: preemption in both directions
    do_reset();
    len0 = 0; len1 = 0; seen1 = 0; back0 = 0;
    for (int i = 0; i < 24; i++) begin
      cyc("preempt", 1'b1, (i >= 2), 1'b1);
      if (gnt1) begin
        seen1 = 1;
        if (!back0) len1++;
      end
      if (gnt0) begin
        if (seen1) back0 = 1;
        else len0++;
      end
    end
    check_int("preempt_gnt0_len", len0, MAX_HOLD);
    check_int("preempt_gnt1_len", len1, MAX_HOLD);
    check_int("preempt_back_to_0", int'(back0), 1);

    // 5: lone holder, no preemption and no wrap
    do_reset();
    cnt1 = 0;
    for (int i = 0; i < 20; i++) begin
      cyc("lone_hold", 1'b0, 1'b1, 1'b1);
      if (gnt1) cnt1++;
    end
    check_int("lone_hold_len", cnt1, 20);
    // The other requester rises after saturation and takes over after one cycle.
    cyc("late_other", 1'b1, 1'b1, 1'b1);
    cyc("late_other", 1'b1, 1'b1, 1'b1);
    check("late_other_switch", {busy, gnt1, gnt0}, 3'b101);

    // 6: reset during a grant
    cyc("mid_setup", 1'b0, 1'b0, 1'b1);
    cyc("mid_setup", 1'b0, 1'b1, 1'b1);
    cyc("mid_setup", 1'b1, 1'b1, 1'b1);
    check("mid_setup_g1", {busy, gnt1, gnt0}, 3'b110);
    cyc("mid_reset", 1'b1, 1'b1, 1'b0);
    check("mid_reset_drop", {busy, gnt1, gnt0}, 3'b000);
    cyc("post_reset", 1'b1, 1'b1, 1'b1);
    check("post_reset_first_0", {busy, gnt1, gnt0}, 3'b101);

    // Glitch: a 1-cycle request still gets at least one grant cycle.
    cyc("glitch_idle", 1'b0, 1'b0, 1'b1);
    cyc("glitch_idle", 1'b0, 1'b0, 1'b1);
    cyc("glitch", 1'b0, 1'b1, 1'b1);
    check("glitch_granted", {busy, gnt1, gnt0}, 3'b110);
    cyc("glitch_end", 1'b0, 1'b0, 1'b1);

    // Random: requests toggle occasionally so that long holds happen, with
    // sparse resets.
    r0 = 1'b0; r1 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r0 = ~r0;
      if ($urandom_range(0, 3) == 0) r1 = ~r1;
      rn = ($urandom_range(0, 79) != 0);
      cyc("random", r0, r1, rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
